// File: rtl/usb_cmd_bridge.sv
// usb_cmd_bridge: turns USB FIFO command packets into word reads/writes on the mux_usb port.
// Ports: clk/rst_n (sync, active-low); rx_* byte stream in; tx_* byte stream out;
// usb_addr/usb_rd/usb_wr/usb_wr_data/usb_rd_data/usb_rd_valid/usb_wr_ready word port; busy.
// Define USB_CMD_BRIDGE_ACK_EN to send a 0x4B byte at the end of every packet.
module usb_cmd_bridge #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [25:0] usb_addr,
  output logic        usb_rd,
  output logic        usb_wr,
  output logic [31:0] usb_wr_data,
  input  logic [31:0] usb_rd_data,
  input  logic        usb_rd_valid,
  input  logic        usb_wr_ready,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, HDR, WDATA, WISSUE, RISSUE, RWAIT, RSEND, ACK} state_t;
`ifdef USB_CMD_BRIDGE_ACK_EN
  localparam state_t DONE = ACK;
`else
  localparam state_t DONE = IDLE;
`endif
  state_t state, state_nxt;
  logic run, is_wr, rx_fire, tx_fire, in_rx, timeout, last;
  logic [2:0] hcnt;
  logic [1:0] bcnt;
  logic [15:0] words;
  logic [31:0] rdata;
  logic [TW-1:0] tcnt;
  // run keeps rx_ready low while reset is asserted and raises it the cycle after release
  assign in_rx = state == HDR || state == WDATA;
  assign rx_ready = run && (state == IDLE || in_rx);
  assign rx_fire = rx_valid && rx_ready;
  assign tx_valid = state == RSEND || state == ACK;
  assign tx_fire = tx_valid && tx_ready;
  assign tx_data = state == RSEND ? rdata[{bcnt, 3'b000} +: 8] : state == ACK ? 8'h4B : 8'h00;
  assign usb_wr = state == WISSUE;
  assign usb_rd = state == RISSUE;
  assign busy = state != IDLE;
  assign timeout = in_rx && !rx_fire && tcnt == TW'(TIMEOUT_CYC - 1);
  assign last = words == 16'd1;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (rx_fire && (rx_data == 8'h57 || rx_data == 8'h52)) state_nxt = HDR;
      HDR:    if (rx_fire && hcnt == 3'd5) state_nxt = {rx_data, words[7:0]} == 16'd0 ? DONE : is_wr ? WDATA : RISSUE;
      WDATA:  if (rx_fire && bcnt == 2'd3) state_nxt = WISSUE;
      WISSUE: if (usb_wr_ready) state_nxt = last ? DONE : WDATA;
      RISSUE: state_nxt = RWAIT;
      RWAIT:  if (usb_rd_valid) state_nxt = RSEND;
      RSEND:  if (tx_fire && bcnt == 2'd3) state_nxt = last ? DONE : RISSUE;
      ACK:    if (tx_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      run <= 1'b0;
      is_wr <= 1'b0;
      hcnt <= '0;
      bcnt <= '0;
      words <= '0;
      rdata <= '0;
      tcnt <= '0;
      usb_addr <= '0;
      usb_wr_data <= '0;
    end else begin
      run <= 1'b1;
      tcnt <= (rx_fire || !in_rx) ? '0 : tcnt + 1'b1;
      if (state == IDLE) begin
        hcnt <= '0;
        bcnt <= '0;
        if (rx_fire) is_wr <= rx_data == 8'h57;
      end
      if (state == HDR && rx_fire) begin
        hcnt <= hcnt + 3'd1;
        case (hcnt)
          3'd0: usb_addr[7:0] <= rx_data;
          3'd1: usb_addr[15:8] <= rx_data;
          3'd2: usb_addr[23:16] <= rx_data;
          3'd3: usb_addr[25:24] <= rx_data[1:0];
          3'd4: words[7:0] <= rx_data;
          3'd5: words[15:8] <= rx_data;
          default: ;
        endcase
      end
      if (state == WDATA && rx_fire) begin
        usb_wr_data <= {rx_data, usb_wr_data[31:8]};
        bcnt <= bcnt + 2'd1;
      end
      if (state == RSEND && tx_fire) bcnt <= bcnt + 2'd1;
      if (state == RWAIT && usb_rd_valid) rdata <= usb_rd_data;
      if ((state == WISSUE && usb_wr_ready) || (state == RSEND && tx_fire && bcnt == 2'd3)) begin
        usb_addr <= usb_addr + 26'd4;
        words <= words - 16'd1;
      end
    end
endmodule
